fifo_ctrl16: RTL and testbench

FIFO_CTRL16 -- requirements
Module: fifo_ctrl16

---
 rtl/fifo_pkg.sv | 38 +++
 rtl/fifo_ctrl16_wrap_ptr4.sv | 21 ++
 rtl/fifo_ctrl16.sv | 138 +++++++++++++
 tb/tb_fifo_ctrl16.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16-entry FIFO controller.
// Used by fifo_ctrl16 and its pointer sub-module.
package fifo_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int CW    = AW + 1;

    // Which memory operation the controller issues this cycle.
    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_PUSH = 2'd1,
        REQ_POP  = 2'd2
    } req_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    // Occupancy flags decoded purely from the registered count.
    function automatic flags_t decode_flags(
        input logic [CW-1:0] count,
        input int            af_level,
        input int            ae_level
    );
        flags_t f;
        f.full         = (int'(count) == DEPTH);
        f.empty        = (count == '0);
        f.almost_full  = (int'(count) >= af_level);
        f.almost_empty = (int'(count) <= ae_level);
        return f;
    endfunction

endpackage

// File: rtl/fifo_ctrl16_wrap_ptr4.sv
// 4-bit wrapping pointer with increment enable.
// Wraps 15 -> 0 naturally through the 4-bit add.
module wrap_ptr4
    import fifo_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    // Advance on enable; async clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl16.sv
// Controller for a 16x8 FIFO built on an external single-port
// synchronous memory; writes win over reads in a shared cycle.
module fifo_ctrl16
    import fifo_pkg::*;
#(
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PUSH,
    input  logic [DW-1:0] PUSH_DATA,
    input  logic          POP,
    output logic          POP_READY,
    output logic          POP_VALID,
    output logic [DW-1:0] POP_DATA,
    output logic          FULL,
    output logic          EMPTY,
    output logic          ALMOST_FULL,
    output logic          ALMOST_EMPTY,
    output logic [CW-1:0] COUNT,
    output logic          OVF,
    output logic          UDF,
    output logic          MEM_WR,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DIN,
    input  logic [DW-1:0] MEM_DOUT
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          pop_valid;
    logic          ovf;
    logic          udf;
    flags_t        flags;
    req_e          req;
    logic          push_ok;
    logic          pop_ok;

    assign flags = decode_flags(count, AF_LEVEL, AE_LEVEL);

    // Arbitrate the single memory port: push first, then pop.
    always_comb begin
        req     = REQ_IDLE;
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        if (!RST) begin
            if (PUSH && !flags.full) begin
                req     = REQ_PUSH;
                push_ok = 1'b1;
            end else if (POP && !flags.empty) begin
                req    = REQ_POP;
                pop_ok = 1'b1;
            end
        end
    end

    wrap_ptr4 u_wptr (
        .CLK (CLK),
        .RST (RST),
        .inc (push_ok),
        .ptr (wptr)
    );

    wrap_ptr4 u_rptr (
        .CLK (CLK),
        .RST (RST),
        .inc (pop_ok),
        .ptr (rptr)
    );

    // Occupancy moves by at most one per cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else begin
            unique case (req)
                REQ_PUSH: count <= count + CW'(1);
                REQ_POP:  count <= count - CW'(1);
                default:  count <= count;
            endcase
        end
    end

    // Read data arrives one cycle after the accepted pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
        end
    end

    // Sticky error flags; the rejected request is otherwise ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (PUSH && flags.full) begin
                ovf <= 1'b1;
            end
            if (POP && flags.empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Memory port: write address on a push, read pointer otherwise.
    always_comb begin
        MEM_WR   = 1'b0;
        MEM_ADDR = rptr;
        MEM_DIN  = PUSH_DATA;
        unique case (req)
            REQ_PUSH: begin
                MEM_WR   = 1'b1;
                MEM_ADDR = wptr;
            end
            default: begin
                MEM_WR   = 1'b0;
                MEM_ADDR = rptr;
            end
        endcase
    end

    assign POP_READY    = pop_ok;
    assign POP_VALID    = pop_valid;
    assign POP_DATA     = MEM_DOUT;
    assign COUNT        = count;
    assign FULL         = flags.full;
    assign EMPTY        = flags.empty;
    assign ALMOST_FULL  = flags.almost_full;
    assign ALMOST_EMPTY = flags.almost_empty;
    assign OVF          = ovf;
    assign UDF          = udf;

endmodule

// File: tb/tb_fifo_ctrl16.sv
// Directed bench for fifo_ctrl16 with a behavioural 16x8 memory.
// Expected read data comes from a scoreboard queue.
module tb_fifo_ctrl16;

    logic       CLK;
    logic       RST;
    logic       PUSH;
    logic [7:0] PUSH_DATA;
    logic       POP;
    logic       POP_READY;
    logic       POP_VALID;
    logic [7:0] POP_DATA;
    logic       FULL;
    logic       EMPTY;
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;
    logic [4:0] COUNT;
    logic       OVF;
    logic       UDF;
    logic       MEM_WR;
    logic [3:0] MEM_ADDR;
    logic [7:0] MEM_DIN;
    logic [7:0] MEM_DOUT;

    logic [7:0] mem [16];

    int checks;
    int failures;

    logic [7:0] q[$];
    int         mcount;
    logic [3:0] wp;
    logic [3:0] rp;
    logic       movf;
    logic       mudf;

    fifo_ctrl16 #(
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PUSH         (PUSH),
        .PUSH_DATA    (PUSH_DATA),
        .POP          (POP),
        .POP_READY    (POP_READY),
        .POP_VALID    (POP_VALID),
        .POP_DATA     (POP_DATA),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVF          (OVF),
        .UDF          (UDF),
        .MEM_WR       (MEM_WR),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_DIN      (MEM_DIN),
        .MEM_DOUT     (MEM_DOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single-port synchronous memory: reads only when not writing.
    always @(posedge CLK) begin
        if (MEM_WR) begin
            mem[MEM_ADDR] <= MEM_DIN;
        end else begin
            MEM_DOUT <= mem[MEM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("count", 32'(COUNT), 32'(mcount));
        chk("empty", 32'(EMPTY), 32'(mcount == 0));
        chk("full", 32'(FULL), 32'(mcount == 16));
        chk("almost_full", 32'(ALMOST_FULL), 32'(mcount >= 14));
        chk("almost_empty", 32'(ALMOST_EMPTY), 32'(mcount <= 2));
        chk("ovf", 32'(OVF), 32'(movf));
        chk("udf", 32'(UDF), 32'(mudf));
    endtask

    task automatic model_reset();
        q.delete();
        mcount = 0;
        wp     = '0;
        rp     = '0;
        movf   = 1'b0;
        mudf   = 1'b0;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic step(input bit push, input bit pop, input logic [7:0] d);
        bit         pa;
        bit         pp;
        logic [7:0] exp_d;
        exp_d     = '0;
        PUSH      = push;
        POP       = pop;
        PUSH_DATA = d;
        pa = push && (mcount != 16);
        pp = pop && (mcount != 0) && !pa;
        #3;
        chk("pop_ready", 32'(POP_READY), 32'(pp));
        chk("mem_wr", 32'(MEM_WR), 32'(pa));
        chk("mem_addr", 32'(MEM_ADDR), 32'(pa ? wp : rp));
        if (pa) chk("mem_din", 32'(MEM_DIN), 32'(d));
        if (push && mcount == 16) movf = 1'b1;
        if (pop && mcount == 0) mudf = 1'b1;
        if (pa) begin
            q.push_back(d);
            wp = wp + 4'd1;
            mcount++;
        end
        if (pp) begin
            exp_d = q.pop_front();
            rp = rp + 4'd1;
            mcount--;
        end
        @(posedge CLK);
        #1;
        chk("pop_valid", 32'(POP_VALID), 32'(pp));
        if (pp) chk("pop_data", 32'(POP_DATA), 32'(exp_d));
        chk_state();
        PUSH = 1'b0;
        POP  = 1'b0;
    endtask

    // Async reset mid-cycle, checked before any clock edge.
    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk("rst_pop_valid", 32'(POP_VALID), 32'd0);
        chk("rst_mem_wr", 32'(MEM_WR), 32'd0);
        chk_state();
        @(posedge CLK);
        #1;
        chk("rst_hold_pop_valid", 32'(POP_VALID), 32'd0);
        RST = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        RST       = 1'b1;
        PUSH      = 1'b0;
        POP       = 1'b0;
        PUSH_DATA = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_pop_valid", 32'(POP_VALID), 32'd0);
        chk("reset_mem_wr", 32'(MEM_WR), 32'd0);
        chk_state();
        RST = 1'b0;

        // Fill with 0x11..0x20; flag sweep is checked every cycle.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
        chk("filled_full", 32'(FULL), 32'd1);
        chk("filled_count", 32'(COUNT), 32'd16);

        // Overflow, then push+pop at full: pop wins, push rejected.
        step(1'b1, 1'b0, 8'h99);
        step(1'b1, 1'b1, 8'h98);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("drained_empty", 32'(EMPTY), 32'd1);

        // Underflow leaves POP_VALID low.
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Write priority at COUNT=3.
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        step(1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Steady occupancy around 5 across several pointer wraps.
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 8'($urandom_range(255)));
            step(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Reset lands during the read-data cycle of an accepted pop.
        async_reset();
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b0, 1'b1, 8'h00);
        async_reset();
        step(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
